// File: rtl/mul_div_sequencer.sv
// Iterative MULTU/MULT/DIVU sequencer owning HI/LO for the MIPS core.
// Latency: 32 cycles (MULTU/DIVU) or 33 cycles (MULT) from start to HI/LO write.
// Backpressure: stall asserts while busy if decode presents start or readhilo.
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             readhilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t             state, state_nxt;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   opb;          // multiplicand or divisor
  logic [2*WIDTH-1:0] acc;          // mul: {partial, multiplier}; div: {rem, quotient}
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] acc_fix;
  logic [WIDTH:0]     sum;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               is_div, is_signed, neg;
  logic               accept, last;

  assign accept = (state == IDLE) && start && (op != OP_RSVD);
  assign last   = (cnt == 6'(WIDTH - 1));
  assign busy   = (state != IDLE);
  assign stall  = busy && (start || readhilo);

  // Magnitudes for signed multiply; the most negative value maps to itself as unsigned.
  assign abs_a = srca[WIDTH-1] ? (~srca + 1'b1) : srca;
  assign abs_b = srcb[WIDTH-1] ? (~srcb + 1'b1) : srcb;

  // Final sign correction of the unsigned product.
  assign acc_fix = neg ? (~acc + 1'b1) : acc;

  // One datapath step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opb};
    acc_step = acc;
    if (is_div) begin
      if (!trial[WIDTH+1])
        acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_step = {sum, acc[WIDTH-1:1]};
      else
        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = is_signed ? FIX : IDLE;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration, and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      opb       <= '0;
      acc       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            is_div    <= (op == OP_DIVU);
            is_signed <= (op == OP_MULT);
            neg       <= (op == OP_MULT) && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            acc       <= {{WIDTH{1'b0}}, (op == OP_MULT) ? abs_a : srca};
            opb       <= (op == OP_MULT) ? abs_b : srcb;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          acc <= acc_step;
          if (last && !is_signed) begin
            hi   <= acc_step[2*WIDTH-1:WIDTH];
            lo   <= acc_step[WIDTH-1:0];
            done <= 1'b1;
          end
        end
        FIX: begin
          hi   <= acc_fix[2*WIDTH-1:WIDTH];
          lo   <= acc_fix[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer with hand-computed expected results.
// Latency: checks busy length (32/33 cycles), done pulse and HI/LO per vector.
// Backpressure: checks stall under readhilo and start while busy.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        readhilo;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  int n_chk  = 0;
  int n_fail = 0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .readhilo(readhilo),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; waits for busy to fall and checks the result.
  task automatic wait_result(input string tag, input int exp_cyc,
                             input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = 0;
    start = 1'b0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_busycyc"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_hi"}, {32'b0, hi}, {32'b0, eh});
    chk({tag, "_lo"}, {32'b0, lo}, {32'b0, el});
    tick();
    chk({tag, "_done_off"}, {63'b0, done}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; op = o; srca = a; srcb = b;
    tick();
    wait_result(tag, exp_cyc, eh, el);
  endtask

  initial begin
    int bad, n, dcount;
    reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0; readhilo = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'h00000005, 33, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("mult_min",  2'b01, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32, 32'h00000002, 32'h0000000E);
    run_op("divu_by0",  2'b10, 32'h00001234, 32'h0, 32, 32'h00001234, 32'hFFFFFFFF);

    // start + readhilo together in IDLE: no stall, old result visible.
    start = 1'b1; op = 2'b00; srca = 32'd6; srcb = 32'd7; readhilo = 1'b1;
    #1;
    chk("idle_both_stall", {63'b0, stall}, 64'd0);
    chk("idle_both_lo", {32'b0, lo}, 64'hFFFFFFFF);
    tick();
    start = 1'b0;
    bad = 0; n = 0;
    while (busy && n < 200) begin
      #1;
      if (!stall) bad++;
      n++;
      tick();
    end
    chk("rd_stall_held", 64'(bad), 64'd0);
    chk("rd_busycyc", 64'(n), 64'd32);
    chk("rd_stall_after", {63'b0, stall}, 64'd0);
    chk("rd_lo", {32'b0, lo}, 64'h2A);
    chk("rd_hi", {32'b0, hi}, 64'h0);
    readhilo = 1'b0;
    tick();

    // Second start while busy: stalled, accepted in the done cycle.
    start = 1'b1; op = 2'b00; srca = 32'd3; srcb = 32'd4;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; op = 2'b10; srca = 32'd50; srcb = 32'd5;
    #1;
    chk("b2b_stall", {63'b0, stall}, 64'd1);
    bad = 0; n = 0;
    while (busy && n < 200) begin
      if (!stall) bad++;
      n++;
      tick();
    end
    chk("b2b_stall_held", 64'(bad), 64'd0);
    chk("b2b_first_lo", {32'b0, lo}, 64'd12);
    chk("b2b_first_hi", {32'b0, hi}, 64'd0);
    chk("b2b_first_done", {63'b0, done}, 64'd1);
    chk("b2b_idle_stall", {63'b0, stall}, 64'd0);
    tick();
    chk("b2b_accepted", {63'b0, busy}, 64'd1);
    wait_result("b2b_divu", 32, 32'd0, 32'd10);

    // Reset during RUN cycle 10 aborts without a write.
    start = 1'b1; op = 2'b00; srca = 32'hFFFFFFFF; srcb = 32'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_hi", {32'b0, hi}, 64'd0);
    chk("abort_lo", {32'b0, lo}, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    run_op("divu_9_2", 2'b10, 32'd9, 32'd2, 32, 32'd1, 32'd4);

    // Reserved op is ignored.
    start = 1'b1; op = 2'b11; srca = 32'd5; srcb = 32'd5;
    tick();
    chk("rsvd_busy", {63'b0, busy}, 64'd0);
    start = 1'b0;
    tick();
    chk("rsvd_busy2", {63'b0, busy}, 64'd0);
    chk("rsvd_lo", {32'b0, lo}, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
# mul_div_sequencer

Iterative multiply/divide controller that sequences a shared 32-bit shift-add / restoring-subtract datapath and owns the HI/LO result registers for the MIPS core. It sits beside the core datapath: decode issues MULT/MULTU/DIVU with operands from the register file, and MFHI/MFLO read results from it. While an operation runs, the block stalls the pipeline on any conflicting access.

## Interface

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. The test plan uses 32 only.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  decode has a mul/div instruction this cycle
- op  in  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 reserved
- srca  in  WIDTH  rs operand (multiplicand / dividend)
- srcb  in  WIDTH  rt operand (multiplier / divisor)
- readhilo  in  1  decode has MFHI or MFLO this cycle
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)
- busy  out  1  operation in progress
- stall  out  1  core must hold its current instruction
- done  out  1  one-cycle pulse after HI/LO update

## Operation

- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op≠11 latches operands, clears the 6-bit iteration counter, and goes to RUN.
  - op=11 is ignored: no state change, no busy.
- MULTU / DIVU: the operands are used as given.
- MULT:
  - Latch |srca| and |srcb|.
  - Record neg = srca[31] ^ srcb[31].
  - |0x80000000| = 0x80000000, treated as unsigned.
- RUN, multiply: one shift-add step per cycle, unsigned, over a 64-bit accumulator.
- RUN, divide: one restoring-subtract step per cycle, producing a 32-bit quotient and remainder.
- Counter: increments each RUN cycle. After the 32nd RUN cycle:
  - MULTU/DIVU write HI/LO and go to IDLE.
  - MULT goes to FIX.
- FIX (one cycle): if neg, two's-complement negate the 64-bit product. Then write HI/LO and go to IDLE.
- DIVU by zero: no special case. The restoring algorithm naturally yields lo=0xFFFFFFFF and hi=srca.
- Output decode:
  - busy = (state≠IDLE).
  - stall = busy & (start | readhilo).
- Start while busy: ignored. The core stalls and re-presents it, so it is accepted in the first IDLE cycle.
- readhilo with busy=0: hi/lo outputs hold the last written result, valid combinationally from the registers.
- start and readhilo both high in IDLE:
  - start is accepted.
  - readhilo sees the old HI/LO this cycle, with no stall.
- HI/LO change only at the result-write edge or on reset.

## Timing

- Reset values: hi=0, lo=0, busy=0, stall=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts with no HI/LO write. All outputs take reset values at that edge. start is accepted on the next edge after reset deasserts.
- Let start be sampled at edge E0:
  - busy is high from E0 to E32 for MULTU/DIVU (32 cycles) and from E0 to E33 for MULT (33 cycles).
  - HI/LO are written at E32 (MULTU/DIVU) or E33 (MULT), the same edge at which busy falls.
  - done is registered and high for exactly one cycle after the write edge. During that cycle state=IDLE, so a new start is accepted (back-to-back issue).
- stall is combinational from start/readhilo and registered busy. There is no combinational path from srca/srcb to any output.
- Throughput: one operation per 33 cycles (MULTU/DIVU) or per 34 cycles (MULT).

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy exactly 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT 0xFFFFFFFD (-3) × 0x00000005 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIVU 100 / 7 -> lo=0x0000000E, hi=0x00000002. DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234.
- Issue MULTU 6×7, then hold readhilo=1 from the next cycle -> stall=1 until busy falls. After that, stall=0 and lo=0x0000002A, hi=0.
- Second start during busy -> stall=1, first result unaffected. Second op accepted in the done cycle, and its result is correct 32 cycles later.
- Reset asserted at RUN cycle 10 of a MULTU -> hi=lo=0, busy=0, done never pulses. A following DIVU 9/2 -> lo=4, hi=1. Also op=11 with start -> busy stays 0.
